// File: rtl/maxpool2x2_if.sv
// Bus bundle between maxpool2x2, its y memory, its z memory and the controller.
// The master side is the pooling block; the slave side is the surrounding system.
interface maxpool2x2_if #(
  parameter int DW  = 8,
  parameter int IAW = 4,
  parameter int OAW = 2
);
  logic                  start;
  logic [IAW-1:0]        y_raddr;
  logic signed [DW-1:0]  y_rdata;
  logic [OAW-1:0]        z_waddr;
  logic signed [DW-1:0]  z_wdata;
  logic                  z_wenable;
  logic                  busy;
  logic                  finish;

  modport master (
    input  start, y_rdata,
    output y_raddr, z_waddr, z_wdata, z_wenable, busy, finish
  );

  modport slave (
    output start, y_rdata,
    input  y_raddr, z_waddr, z_wdata, z_wenable, busy, finish
  );
endinterface

// File: rtl/maxpool2x2.sv
// 2x2 stride-2 signed max pooling from the conv output map (y memory) into z memory.
// Reads one y word per cycle in window order, keeps a running window max, and
// writes one pooled pixel per window. Define MAXPOOL_RELU_EN to clamp negative
// pooled results to zero before they are written.
module maxpool2x2 #(
  parameter int IN_W = 4,
  parameter int IN_H = 4,
  parameter int DW   = 8,
  parameter int IAW  = 4,
  parameter int OAW  = 2
) (
  input  logic         clk,
  input  logic         xrst,
  maxpool2x2_if.master bus
);

  localparam int PW = IN_W / 2;
  localparam int PH = IN_H / 2;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam int RW = (PH > 1) ? $clog2(PH) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           pos_q, pos_d;
  logic [CW-1:0]        pcol_q, pcol_d;
  logic [RW-1:0]        prow_q, prow_d;
  logic                 rvalid_q, rvalid_d;
  logic [1:0]           spos_q, spos_d;
  logic [OAW-1:0]       win_q, win_d;
  logic signed [DW-1:0] max_q, max_d;
  logic signed [DW-1:0] zdata_q, zdata_d;
  logic [OAW-1:0]       zaddr_q, zaddr_d;
  logic                 zwe_q, zwe_d;
  logic                 lastAddr;
  logic signed [DW-1:0] rdata;
  logic signed [DW-1:0] windowMax;
  logic signed [DW-1:0] poolOut;
  logic [IAW-1:0]       readAddr;

  assign rdata    = $signed(bus.y_rdata);
  assign lastAddr = (pos_q == 2'd3) && (pcol_q == CW'(PW - 1)) && (prow_q == RW'(PH - 1));

  // State register; reset aborts any run in progress
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DRAIN lasts until the final sample has been consumed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    if (lastAddr)  state_d = DRAIN;
      DRAIN:   if (!rvalid_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == READ) || (state_q == DRAIN);
  assign bus.finish = (state_q == DONE);

  // Read-side address: window-major walk, 2x2 pixels inside each window
  always_comb begin
    readAddr = IAW'((2 * int'(prow_q) + int'(pos_q[1])) * IN_W
                    + 2 * int'(pcol_q) + int'(pos_q[0]));
    bus.y_raddr = (state_q == READ) ? readAddr : '0;
  end

  // Running max of the current window plus optional clamp of the final value
  always_comb begin
    if (spos_q == 2'd0)        windowMax = rdata;
    else if (rdata > max_q)    windowMax = rdata;
    else                       windowMax = max_q;
`ifdef MAXPOOL_RELU_EN
    poolOut = windowMax[DW-1] ? '0 : windowMax;
`else
    poolOut = windowMax;
`endif
  end

  // Next values for read counters, consume counters, max register and z outputs
  always_comb begin
    pos_d    = '0;
    pcol_d   = '0;
    prow_d   = '0;
    rvalid_d = (state_q == READ);
    spos_d   = spos_q;
    win_d    = win_q;
    max_d    = max_q;
    zdata_d  = zdata_q;
    zaddr_d  = zaddr_q;
    zwe_d    = 1'b0;
    if (state_q == READ) begin
      pos_d  = pos_q + 2'd1;
      pcol_d = pcol_q;
      prow_d = prow_q;
      if (pos_q == 2'd3) begin
        if (pcol_q == CW'(PW - 1)) begin
          pcol_d = '0;
          prow_d = (prow_q == RW'(PH - 1)) ? '0 : prow_q + RW'(1);
        end else begin
          pcol_d = pcol_q + CW'(1);
        end
      end
    end
    if (rvalid_q) begin
      max_d  = windowMax;
      spos_d = spos_q + 2'd1;
      if (spos_q == 2'd3) begin
        win_d   = win_q + OAW'(1);
        zwe_d   = 1'b1;
        zaddr_d = win_q;
        zdata_d = poolOut;
      end
    end
    if (state_q == DONE) begin
      spos_d = '0;
      win_d  = '0;
    end
  end

  // Datapath registers; z address/data hold between writes
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      pos_q    <= '0;
      pcol_q   <= '0;
      prow_q   <= '0;
      rvalid_q <= 1'b0;
      spos_q   <= '0;
      win_q    <= '0;
      max_q    <= '0;
      zdata_q  <= '0;
      zaddr_q  <= '0;
      zwe_q    <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      pcol_q   <= pcol_d;
      prow_q   <= prow_d;
      rvalid_q <= rvalid_d;
      spos_q   <= spos_d;
      win_q    <= win_d;
      max_q    <= max_d;
      zdata_q  <= zdata_d;
      zaddr_q  <= zaddr_d;
      zwe_q    <= zwe_d;
    end
  end

  assign bus.z_wdata   = zdata_q;
  assign bus.z_waddr   = zaddr_q;
  assign bus.z_wenable = zwe_q;

endmodule
